// File: rtl/prescaler_pkg.sv
//------------------------------------------------------------------------------
// Module   : prescaler_pkg
// Brief    : Shared state encoding and width helper for the tick prescaler.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package prescaler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } ps_state_t;

  function automatic int cnt_width(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler_if.sv
//------------------------------------------------------------------------------
// Module   : tick_prescaler_if
// Brief    : Button, clear and tick/phase signals of the tick prescaler.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface tick_prescaler_if #(
  parameter int DIV = 50_000_000
);
  import prescaler_pkg::*;

  localparam int CNT_W = cnt_width(DIV);

  logic             start_btn;
  logic             stop_btn;
  logic             clear;
  logic             tick;
  logic             running;
  logic [CNT_W-1:0] phase;

  modport master (
    output start_btn, stop_btn, clear,
    input  tick, running, phase
  );

  modport slave (
    input  start_btn, stop_btn, clear,
    output tick, running, phase
  );

endinterface

`default_nettype wire

// File: rtl/btn_sync_edge.sv
//------------------------------------------------------------------------------
// Module   : btn_sync_edge
// Brief    : Two-flop synchroniser with a one-cycle rising-edge event output.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btn_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_evt
);

  logic r_s0;
  logic r_s1;
  logic r_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
      r_p  <= 1'b0;
    end else begin
      r_s0 <= i_btn;
      r_s1 <= r_s0;
      r_p  <= r_s1;
    end
  end

  // History resets low, so a button held through reset still yields one event.
  assign o_evt = r_s1 & ~r_p;

endmodule

`default_nettype wire

// File: rtl/tick_prescaler.sv
//------------------------------------------------------------------------------
// Module   : tick_prescaler
// Brief    : Start/stop controlled enable generator, one tick every DIV cycles.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tick_prescaler #(
  parameter int DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  tick_prescaler_if.slave  bus
);
  import prescaler_pkg::*;

  localparam int               CNT_W        = cnt_width(DIV);
  localparam logic [CNT_W-1:0] c_last_phase = CNT_W'(DIV - 1);

  ps_state_t        r_state;
  ps_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] w_phase_nxt;
  logic             w_start_evt;
  logic             w_stop_evt;
  logic             w_phase_last;

  btn_sync_edge u_start_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_btn   (bus.start_btn),
    .o_evt   (w_start_evt)
  );

  btn_sync_edge u_stop_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_btn   (bus.stop_btn),
    .o_evt   (w_stop_evt)
  );

  assign w_phase_last = (r_phase == c_last_phase);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Clear beats both buttons; stop beats start when both events coincide.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    if (bus.clear) begin
      w_state_nxt = IDLE;
      w_phase_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_phase_nxt = '0;
          if (w_start_evt && !w_stop_evt) begin
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (w_stop_evt) begin
            w_state_nxt = PAUSE;
          end else if (w_phase_last) begin
            w_phase_nxt = '0;
          end else begin
            w_phase_nxt = r_phase + CNT_W'(1);
          end
        end
        PAUSE: begin
          if (w_start_evt && !w_stop_evt) begin
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_phase_nxt = '0;
        end
      endcase
    end
  end

  assign bus.running = (r_state == RUN);
  assign bus.tick    = (r_state == RUN) && w_phase_last;
  assign bus.phase   = r_phase;

endmodule

`default_nettype wire

// File: tb/tb_tick_prescaler.sv
//------------------------------------------------------------------------------
// Module   : tb_tick_prescaler
// Brief    : Directed vector bench for tick_prescaler at DIV = 4 and DIV = 1.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tick_prescaler;

  typedef struct {
    logic       start;
    logic       stop;
    logic       clr;
    logic       run;
    logic       tck;
    logic [1:0] ph;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  vec_t vecs[$];

  tick_prescaler_if #(.DIV(4)) bus4 ();
  tick_prescaler_if #(.DIV(1)) bus1 ();

  tick_prescaler #(.DIV(4)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus4)
  );

  tick_prescaler #(.DIV(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic cl,
                     input logic run, input logic tck, input logic [1:0] ph);
    vecs.push_back('{start: st, stop: sp, clr: cl, run: run, tck: tck, ph: ph});
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit got;
    checks         = 0;
    errors         = 0;
    reset_n        = 1'b0;
    bus4.start_btn = 1'b0;
    bus4.stop_btn  = 1'b0;
    bus4.clear     = 1'b0;
    bus1.start_btn = 1'b0;
    bus1.stop_btn  = 1'b0;
    bus1.clear     = 1'b0;

    // start held 10 cycles, stop at phase 2, resume, coincident presses, clears
    for (int i = 0; i < 10; i++) begin
      case (i)
        0, 1:    add(1, 0, 0, 0, 0, 0);
        5, 9:    add(1, 0, 0, 1, 1, 3);
        default: add(1, 0, 0, 1, 0, 2'((i - 2) % 4));
      endcase
    end
    add(0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 1, 0, 1);
    add(0, 1, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 2);
    add(0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 1, 1, 3);
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 1);
    add(1, 1, 0, 1, 0, 2);
    add(0, 0, 0, 1, 1, 3);
    add(0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 3);
    add(1, 1, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 3);
    add(0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 1, 0, 2);
    add(0, 0, 0, 1, 1, 3);
    add(0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_running", int'(bus4.running), 0);
    check("reset_tick", int'(bus4.tick), 0);
    check("reset_phase", int'(bus4.phase), 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus4.start_btn = vecs[i].start;
      bus4.stop_btn  = vecs[i].stop;
      bus4.clear     = vecs[i].clr;
      step_edge();
      check($sformatf("vec%0d_running", i), int'(bus4.running), int'(vecs[i].run));
      check($sformatf("vec%0d_tick", i), int'(bus4.tick), int'(vecs[i].tck));
      check($sformatf("vec%0d_phase", i), int'(bus4.phase), int'(vecs[i].ph));
    end

    // asynchronous reset while tick is high
    @(negedge clk);
    bus4.start_btn = 1'b1;
    @(negedge clk);
    bus4.start_btn = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      step_edge();
      if (bus4.tick) got = 1'b1;
    end
    check("wait_tick", int'(got), 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_tick", int'(bus4.tick), 0);
    check("async_rst_running", int'(bus4.running), 0);
    check("async_rst_phase", int'(bus4.phase), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step_edge();
      check("post_rst_running", int'(bus4.running), 0);
      check("post_rst_phase", int'(bus4.phase), 0);
    end

    // start held through reset release gives one event
    @(negedge clk);
    reset_n        = 1'b0;
    bus4.start_btn = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    step_edge();
    check("held_rst_e1", int'(bus4.running), 0);
    step_edge();
    check("held_rst_e2", int'(bus4.running), 0);
    step_edge();
    check("held_rst_e3_running", int'(bus4.running), 1);
    check("held_rst_e3_phase", int'(bus4.phase), 0);
    @(negedge clk);
    bus4.start_btn = 1'b0;

    // DIV = 1: tick continuous in RUN, drops with running on stop
    @(negedge clk);
    bus1.start_btn = 1'b1;
    step_edge();
    check("div1_k0_running", int'(bus1.running), 0);
    @(negedge clk);
    bus1.start_btn = 1'b0;
    step_edge();
    check("div1_k1_running", int'(bus1.running), 0);
    step_edge();
    check("div1_run", int'(bus1.running), 1);
    for (int c = 0; c < 5; c++) begin
      check("div1_tick", int'(bus1.tick), 1);
      check("div1_phase", int'(bus1.phase), 0);
      step_edge();
    end
    @(negedge clk);
    bus1.stop_btn = 1'b1;
    step_edge();
    check("div1_stop_k0_tick", int'(bus1.tick), 1);
    @(negedge clk);
    bus1.stop_btn = 1'b0;
    step_edge();
    check("div1_stop_k1_tick", int'(bus1.tick), 1);
    step_edge();
    check("div1_stop_tick", int'(bus1.tick), 0);
    check("div1_stop_running", int'(bus1.running), 0);
    check("div1_stop_phase", int'(bus1.phase), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tick_prescaler.md
# tick_prescaler

Run-controlled clock-enable generator that sits directly upstream of the lab down counter and drives its count enable. It synchronises two asynchronous push-button inputs (start, stop), turns them into single-cycle edge events, and while running emits a one-cycle `tick` every `DIV` clock cycles. The downstream counter decrements only on `tick`, giving a human-visible count rate from the fast board clock.

## Interface
- `DIV`, default 50_000_000: tick period in clock cycles; legal range ≥ 1.
- `CNT_W`, default max(1, $clog2(DIV)): width of the phase counter; derived, not overridden.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_btn`  in  1  asynchronous level from the button; its rising edge requests run.
- `stop_btn`  in  1  asynchronous level from the button; its rising edge requests pause.
- `clear`  in  1  synchronous, active-high; returns the block to idle.
- `tick`  out  1  one-cycle enable pulse for the downstream counter.
- `running`  out  1  high while state is RUN.
- `phase`  out  CNT_W  current prescaler count.

## Operation
- Each button passes through a 2-flop synchroniser (s0 → s1) plus a history flop p. Edge event = s1 & ~p. A held button yields exactly one event per press.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: `phase` = 0. Start event → RUN. Stop event is ignored.
  - RUN: `phase` increments by 1 each cycle and wraps from DIV-1 to 0. Stop event → PAUSE.
  - PAUSE: `phase` holds its value. Start event → RUN, resuming from the held phase.
- Simultaneous start and stop events: stop wins.
  - IDLE stays IDLE.
  - RUN goes to PAUSE.
  - PAUSE stays PAUSE.
- `clear` has priority over both button events. From any state it gives IDLE and `phase` = 0 at the next edge.
- `tick` = (state == RUN) && (phase == DIV-1). It is decoded from registered state only and is glitch-free.
- `running` = (state == RUN).
- DIV = 1: `phase` is constantly 0, and `tick` is high every cycle while in RUN.
- Reset (reset_n low, asynchronous): state IDLE, `phase` 0, all synchroniser and history flops 0. Therefore `tick` = 0 and `running` = 0 immediately, including mid-run.
- A button held high through reset release produces one event once it reaches s1, because p resets to 0.

## Timing
- Let a button be high at rising edge k.
  - s0 = 1 after edge k; s1 = 1 after edge k+1.
  - The event is asserted during cycle k+1 → k+2.
  - The state changes at edge k+2.
- Start latency: `running` goes high 2 edges after first sampling.
  - The first increment occurs at edge k+3.
  - The first `tick` occurs in the cycle after edge k+DIV+1, starting from IDLE.
  - Subsequent ticks arrive exactly every DIV cycles.
- Stop latency: 2 edges.
  - `phase` freezes at edge k+2.
  - If `phase` = DIV-1 at the freeze, `tick` drops with `running`.
- `clear` latency: 1 edge. `phase` = 0 and `tick` = 0 in the following cycle.
- `tick` duty: exactly 1 cycle per DIV cycles of RUN time. Cycles spent in PAUSE do not count.

## Structure
- Shared package `prescaler_pkg`:
  - state enum `ps_state_t` with encodings IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10;
  - encoding 2'b11 is illegal and recovers to IDLE at the next edge.
- Sub-module `btn_sync_edge`: 2-flop synchroniser plus rising-edge detector with an asynchronous active-low reset. Instantiated twice, once for start and once for stop.
- Top level holds the FSM, the phase counter and the output decode.

## Test plan
- Reset: assert reset_n = 0 mid-RUN with DIV = 4 → `tick`, `running` and `phase` read 0 in the same cycle; after release the state stays IDLE.
- Start with DIV = 4 and `start_btn` held high for 10 cycles → exactly one start event.
  - `running` rises 2 edges after first sampling.
  - `phase` sequence 0, 1, 2, 3, 0, ….
  - `tick` is high only when `phase` = 3, once per 4 cycles.
- Pause and resume: press stop when `phase` = 2 → `phase` holds 2 with no `tick`. Then press start → `phase` resumes 2 → 3 and `tick` fires one cycle after `running` rises.
- Simultaneous start and stop edges in RUN → PAUSE. The same pair in IDLE → stays IDLE with `phase` 0.
- Clear: pulse `clear` in RUN at `phase` = 3, together with a start event → next cycle state is IDLE, `phase` = 0 and `tick` = 0.
- DIV = 1: after start, `tick` is continuously high while RUN and `phase` stays 0. A stop event drops `tick` with `running`.
